// File: rtl/alu_result_fifo.sv
// alu_result_fifo: captures one tagged ALU unit result per cycle into a small
// FIFO and drains it to the consumer over a valid/ready handshake.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   Arith_Out/Arith_Flag      arithmetic result and its valid flag  (unit 00)
//   Logic_Out/Logic_Flag      logic result and its valid flag       (unit 01)
//   CMP_Out/CMP_Flag          compare result and its valid flag     (unit 10)
//   Shift_Out/Shift_Flag      shift result and its valid flag       (unit 11)
//   Res_Ready                 consumer accepts the head entry
//   Clr_Err                   clears the sticky Overflow/Flag_Err bits
//   Res_Data/Res_Unit         head entry data and unit code
//   Res_Valid                 head entry is valid (FIFO non-empty)
//   Count/Full/Empty          occupancy and its decodes
//   Overflow                  sticky: capture dropped because FIFO was full
//   Flag_Err                  sticky: more than one unit flag in one cycle
module alu_result_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] Arith_Out,
   input  logic              Arith_Flag,
   input  logic [DATA_W-1:0] Logic_Out,
   input  logic              Logic_Flag,
   input  logic [DATA_W-1:0] CMP_Out,
   input  logic              CMP_Flag,
   input  logic [DATA_W-1:0] Shift_Out,
   input  logic              Shift_Flag,
   input  logic              Res_Ready,
   input  logic              Clr_Err,
   output logic [DATA_W-1:0] Res_Data,
   output logic [1:0]        Res_Unit,
   output logic              Res_Valid,
   output logic [PTR_W:0]    Count,
   output logic              Full,
   output logic              Empty,
   output logic              Overflow,
   output logic              Flag_Err
);

   logic [DATA_W-1:0] r_mem_data [DEPTH];
   logic [1:0]        r_mem_unit [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              r_overflow;
   logic              r_flag_err;

   logic [3:0]        w_flags;
   logic              w_multi;
   logic              w_push_req;
   logic [DATA_W-1:0] w_push_data;
   logic [1:0]        w_push_unit;
   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;

   assign w_flags = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};

   // Clearing the lowest set bit leaves something only if two or more are set.
   assign w_multi    = (w_flags & (w_flags - 4'd1)) != 4'd0;
   assign w_push_req = (w_flags != 4'd0) && !w_multi;

   always_comb begin
      w_push_data = '0;
      w_push_unit = 2'b00;
      case (1'b1)
         Arith_Flag: begin
            w_push_data = Arith_Out;
            w_push_unit = 2'b00;
         end
         Logic_Flag: begin
            w_push_data = Logic_Out;
            w_push_unit = 2'b01;
         end
         CMP_Flag: begin
            w_push_data = CMP_Out;
            w_push_unit = 2'b10;
         end
         Shift_Flag: begin
            w_push_data = Shift_Out;
            w_push_unit = 2'b11;
         end
         default: begin
            w_push_data = '0;
            w_push_unit = 2'b00;
         end
      endcase
   end

   assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && Res_Ready;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push = w_push_req && (!w_full || w_pop);
   assign w_drop = w_push_req && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_flag_err <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_unit[i] <= 2'b00;
         end
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_unit[r_wr_ptr] <= w_push_unit;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (PTR_W+1)'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - (PTR_W+1)'(1);
         end
         // A new error event in the same cycle as Clr_Err keeps the bit set.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (Clr_Err) begin
            r_overflow <= 1'b0;
         end
         if (w_multi) begin
            r_flag_err <= 1'b1;
         end else if (Clr_Err) begin
            r_flag_err <= 1'b0;
         end
      end
   end

   assign Res_Data  = r_mem_data[r_rd_ptr];
   assign Res_Unit  = r_mem_unit[r_rd_ptr];
   assign Res_Valid = !w_empty;
   assign Count     = r_count;
   assign Full      = w_full;
   assign Empty     = w_empty;
   assign Overflow  = r_overflow;
   assign Flag_Err  = r_flag_err;

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the signed 16-bit ALU top.
- Each cycle it watches the four unit result/flag pairs (arithmetic, logic, compare, shift).
- When exactly one unit flag is high, it captures that unit's result, tagged with a 2-bit unit code, into a small FIFO.
- Results drain to the consumer (writeback/debug port) over a valid/ready handshake. Flag-protocol violations and overflow raise sticky error bits.

Parameters:
DATA_W, 16, width of every result word and of Res_Data.
DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
Arith_Out  input  DATA_W  signed arithmetic result.
Arith_Flag  input  1  arithmetic result valid this cycle.
Logic_Out  input  DATA_W  logic result.
Logic_Flag  input  1  logic result valid.
CMP_Out  input  DATA_W  compare result.
CMP_Flag  input  1  compare result valid.
Shift_Out  input  DATA_W  shift result.
Shift_Flag  input  1  shift result valid.
Res_Ready  input  1  consumer accepts head entry.
Clr_Err  input  1  clears Overflow and Flag_Err.
Res_Data  output  DATA_W  head entry data.
Res_Unit  output  2  head entry unit code: 00 arith, 01 logic, 10 cmp, 11 shift.
Res_Valid  output  1  FIFO non-empty, head is valid.
Count  output  PTR_W+1  current occupancy, 0..DEPTH.
Full  output  1  Count == DEPTH.
Empty  output  1  Count == 0.
Overflow  output  1  sticky: a capture was dropped because the FIFO was full.
Flag_Err  output  1  sticky: more than one unit flag was high in one cycle.

Behaviour:
Reset (rst=1 at a clk edge):
- wr_ptr=0, rd_ptr=0, Count=0; all storage cleared to 0.
- Res_Data=0, Res_Unit=00, Res_Valid=0, Empty=1, Full=0, Overflow=0, Flag_Err=0.
- rst has priority over every other input. Asserting it mid-operation discards all stored entries in that same edge.

Push request:
- push_req = exactly one of the four flags high. The data is that unit's *_Out, the tag is its unit code.
- Zero flags high: no push, no error.
- Two or more flags high: no push; Flag_Err set to 1 at that edge.

Pop:
- pop = Res_Valid & Res_Ready.
- Res_Ready while Empty is ignored; pointers and Count are unchanged.

Write acceptance:
- push_req accepted when !Full, or when Full and pop occurs in the same cycle.
- push_req while Full with no pop: entry dropped, Overflow set to 1, contents unchanged.

Simultaneous push and pop:
- Both pointers advance; Count is unchanged.
- On Empty, push+pop cannot occur, since Res_Valid=0.

Pointers and count:
- Pointers increment modulo DEPTH and wrap with no bubble.
- Count +1 on push only, -1 on pop only.

Latency and outputs:
- An entry captured at edge N shows on Res_Data/Res_Unit, with Res_Valid=1, in the cycle after edge N when the FIFO was empty. There is no combinational path from input flags to Res_Valid.
- Res_Data/Res_Unit are driven from storage at rd_ptr, with Res_Valid=~Empty.
- Head data holds stable while Res_Valid=1 and Res_Ready=0.
- Full and Empty are decoded from the registered Count.

Sticky errors:
- Clr_Err=1 clears Overflow and Flag_Err at the edge.
- If an error event and Clr_Err occur in the same cycle, the error wins and the bit stays set.

Arithmetic:
- Data is stored bit-exact, with no sign extension or truncation (all widths are DATA_W).

Test Plan:
- Reset, then one push: Arith_Flag=1, Arith_Out=16'hFFF1 (-15) for 1 cycle, Res_Ready=0 -> next cycle Res_Valid=1, Res_Data=16'hFFF1, Res_Unit=00, Count=1; all outputs read reset values during rst.
- Ordering across units: push Logic_Out=2, CMP_Out=1, Shift_Out=8 on consecutive cycles, then Res_Ready=1 -> pops return 2/01, 1/10, 8/11 in order; Empty=1 after the 3rd pop.
- Full, drop and recovery: push 5 arith values 1..5 with Res_Ready=0 -> Full=1 and Count=4 after the 4th; the 5th push sets Overflow=1 and value 5 is absent. Then push 6 with Res_Ready=1 on Full -> Count stays 4 and the drained order is 2,3,4,6 after the first pop of 1. Continue 10 push/pop cycles to confirm pointer wrap with correct data.
- Flag error: Arith_Flag=1 and CMP_Flag=1 in the same cycle -> no entry written, Count unchanged, Flag_Err=1. Clr_Err=1 alone clears it. Clr_Err together with a new double-flag keeps Flag_Err=1.
- Edge cases: Res_Ready=1 while Empty -> Count stays 0, no underflow. Mid-stream rst with Count=3 -> next cycle Count=0, Res_Valid=0, Res_Data=0, and a following push behaves as after first reset.
